coax_link_sequencer: RTL

- Half-duplex line sequencer for the coax interface. It sits between `control` and the coax TX/RX datapaths (TX transmitter, `coax_buffered_rx`).
- One transaction runs: kick TX, wait for TX to finish, hold a line turnaround gap, reset and enable RX, then wait for a response frame or a timeout.
- It reports completion status to `control`. It owns the `rx_enable` and `rx_reset` sequencing that `control` drives directly today.

---
 rtl/coax_link_sequencer_pkg.sv | 27 ++
 rtl/coax_link_sequencer_if.sv | 32 +++
 rtl/coax_link_sequencer_bit_timer.sv | 32 +++
 rtl/coax_link_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/coax_link_sequencer_pkg.sv
// Shared encodings for the coax half-duplex line sequencer:
// sequencer states, completion status codes, sizing helper.
package coax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_KICK,
        ST_TX_ARM,
        ST_TX_WAIT,
        ST_TURNAROUND,
        ST_RX_WAIT,
        ST_RX_RECV,
        ST_DONE
    } state_t;

    localparam logic [1:0] STATUS_OK          = 2'd0;
    localparam logic [1:0] STATUS_NO_RESPONSE = 2'd1;
    localparam logic [1:0] STATUS_RX_ERROR    = 2'd2;
    localparam logic [1:0] STATUS_TX_FAULT    = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/coax_link_sequencer_if.sv
// Control + TX/RX handshake bundle around the line sequencer.
// slave = sequencer side, master = control/datapath side.
interface coax_link_sequencer_if;

    logic       start;
    logic       expect_response;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic       tx_start;
    logic       tx_active;
    logic       rx_enable;
    logic       rx_reset;
    logic       rx_active;
    logic       rx_error;

    modport slave (
        input  start, expect_response, abort,
        input  tx_active, rx_active, rx_error,
        output busy, done, status,
        output tx_start, rx_enable, rx_reset
    );

    modport master (
        output start, expect_response, abort,
        output tx_active, rx_active, rx_error,
        input  busy, done, status,
        input  tx_start, rx_enable, rx_reset
    );

endinterface

// File: rtl/coax_link_sequencer_bit_timer.sv
// Loadable down-counter shared by the TX-start, turnaround and
// response timeouts; flags zero now and zero on the next cycle.
module bit_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_tc,
    output logic         o_tc_next
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    // Load wins; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_tc      = (r_count == '0);
    assign o_tc_next = i_load ? (i_value == '0) : (r_count <= ONE);

endmodule

// File: rtl/coax_link_sequencer.sv
// Half-duplex coax line sequencer: TX kick, TX drain, turnaround
// gap, RX reset/enable, then response wait with timeouts.
module coax_link_sequencer
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT        = 16,
    parameter int TURNAROUND_BITS       = 4,
    parameter int RESPONSE_TIMEOUT_BITS = 64,
    parameter int TX_START_TIMEOUT_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    coax_link_sequencer_if.slave bus
);

    localparam int TA_CYC  = TURNAROUND_BITS * CLOCKS_PER_BIT;
    localparam int RSP_CYC = RESPONSE_TIMEOUT_BITS * CLOCKS_PER_BIT;
    localparam int TXS_CYC = TX_START_TIMEOUT_BITS * CLOCKS_PER_BIT;
    localparam int CW = $clog2(max3(TA_CYC, RSP_CYC, TXS_CYC)) + 1;

    localparam logic [CW-1:0] TA_LOAD  = CW'(TA_CYC - 1);
    localparam logic [CW-1:0] RSP_LOAD = CW'(RSP_CYC - 1);
    localparam logic [CW-1:0] TXS_LOAD = CW'(TXS_CYC - 1);

    state_t          r_state;
    logic [1:0]      r_status;
    logic            r_expect;
    logic            r_tx_act;
    logic            r_busy;
    logic            r_done;
    logic            r_tx_start;
    logic            r_rx_enable;
    logic            r_rx_reset;

    state_t          w_state_next;
    logic [1:0]      w_status_next;
    logic            w_load;
    logic [CW-1:0]   w_load_val;
    logic            w_tc;
    logic            w_tc_next;
    logic            w_rx_en_next;

    bit_timer #(.W(CW)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_tc      (w_tc),
        .o_tc_next (w_tc_next)
    );

    // Next state, status update and timer loads; abort overrides all
    // states that own the line.
    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_load        = 1'b0;
        w_load_val    = '0;
        if (bus.abort && r_state != ST_IDLE && r_state != ST_DONE) begin
            w_state_next  = ST_DONE;
            w_status_next = STATUS_TX_FAULT;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) w_state_next = ST_TX_KICK;
                end
                ST_TX_KICK: begin
                    w_state_next = ST_TX_ARM;
                    w_load       = 1'b1;
                    w_load_val   = TXS_LOAD;
                end
                ST_TX_ARM: begin
                    if (r_tx_act) begin
                        w_state_next = ST_TX_WAIT;
                    end else if (w_tc) begin
                        w_state_next  = ST_DONE;
                        w_status_next = STATUS_TX_FAULT;
                    end
                end
                ST_TX_WAIT: begin
                    if (!r_tx_act) begin
                        if (!r_expect) begin
                            w_state_next  = ST_DONE;
                            w_status_next = STATUS_OK;
                        end else begin
                            w_state_next = ST_TURNAROUND;
                            w_load       = 1'b1;
                            w_load_val   = TA_LOAD;
                        end
                    end
                end
                ST_TURNAROUND: begin
                    if (w_tc) begin
                        w_state_next = ST_RX_WAIT;
                        w_load       = 1'b1;
                        w_load_val   = RSP_LOAD;
                    end
                end
                ST_RX_WAIT: begin
                    if (bus.rx_error) begin
                        w_state_next  = ST_DONE;
                        w_status_next = STATUS_RX_ERROR;
                    end else if (bus.rx_active) begin
                        w_state_next = ST_RX_RECV;
                    end else if (w_tc) begin
                        w_state_next  = ST_DONE;
                        w_status_next = STATUS_NO_RESPONSE;
                    end
                end
                ST_RX_RECV: begin
                    if (bus.rx_error) begin
                        w_state_next  = ST_DONE;
                        w_status_next = STATUS_RX_ERROR;
                    end else if (!bus.rx_active) begin
                        w_state_next  = ST_DONE;
                        w_status_next = STATUS_OK;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
        w_rx_en_next = (w_state_next inside
                        {ST_IDLE, ST_RX_WAIT, ST_RX_RECV, ST_DONE});
    end

    // State register; outputs are registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_status    <= STATUS_OK;
            r_expect    <= 1'b0;
            r_tx_act    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tx_start  <= 1'b0;
            r_rx_enable <= 1'b1;
            r_rx_reset  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_status    <= w_status_next;
            r_tx_act    <= bus.tx_active;
            if (r_state == ST_IDLE && bus.start) begin
                r_expect <= bus.expect_response;
            end
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_DONE);
            r_tx_start  <= (w_state_next == ST_TX_KICK);
            r_rx_enable <= w_rx_en_next;
            r_rx_reset  <= (w_state_next == ST_TURNAROUND) && w_tc_next;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.status    = r_status;
    assign bus.tx_start  = r_tx_start;
    assign bus.rx_enable = r_rx_enable;
    assign bus.rx_reset  = r_rx_reset;

endmodule
